bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the system address/data bus between two masters: master 0 is the core's load/store port, master 1 is a secondary requester such as a keyboard-to-text-buffer copier.
- Runs one bus transaction at a time and drives the shared address, write data and read/write strobes to the slaves.
- Decodes the address into device selects for RAM, the VGA text buffer and the keyboard, and returns read data with a one-cycle ready pulse.
- Sits between the masters and the memory-mapped peripherals.

Parameters:
- VGA_BASE, 64'h0000_0000_0000_8000, first address of the VGA text buffer window.
- VGA_SIZE, 64'h0000_0000_0000_1000, size of the VGA window in bytes.
- KBD_ADDR, 64'h0000_0000_0000_9000, single keyboard data register address.
- RAM_SIZE, 64'h0000_0000_0000_4000, RAM occupies 0 to RAM_SIZE-1.
- WAIT_CYCLES, 1, extra cycles strobes are held beyond the first (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  transaction request; address, wdata and rw are held stable while high
- m0_read, m1_read  in  1  read request
- m0_write, m1_write  in  1  write request
- m0_address, m1_address  in  64  byte address
- m0_wdata, m1_wdata  in  64  write data
- m0_ready, m1_ready  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  64  read data, valid while ready is high
- address_bus  out  64  shared bus address
- data_out  out  64  shared bus write data
- read, write  out  1  shared bus strobes
- data_in  in  64  read data returned by the selected slave
- sel_ram, sel_vga, sel_kbd  out  1  one-hot device selects, high only while a strobe is high
- grant  out  1  0 means master 0 owns the bus, 1 means master 1

Behaviour:
- State machine: IDLE, ACCESS, DONE. All outputs are registered.
- Reset values:
  - state is IDLE; every output is 0, including grant.
  - last_grant (internal) is 1, so master 0 wins the first contention.
- IDLE:
  - If exactly one req is high, grant that master.
  - If both are high, grant the master that is not last_grant (round-robin).
  - On the grant edge, latch address, wdata and rw from the winner into the bus registers, load the wait counter with WAIT_CYCLES, update last_grant and grant, and go to ACCESS.
  - With no req, stay in IDLE and hold the bus outputs at 0.
- ACCESS:
  - address_bus and data_out show the latched values.
  - read or write is high. If both were requested, it is a write and read stays 0.
  - Exactly one select is high, per the decode rules below.
  - The counter decrements each cycle. When it is 0, capture data_in into the winner's rdata register and go to DONE.
  - Strobes stay high for exactly WAIT_CYCLES+1 cycles.
- DONE:
  - Strobes and selects are 0; address_bus and data_out are 0.
  - The granted master's ready is high for exactly one cycle, with its rdata valid. The other master's ready and rdata are 0.
  - Then go to IDLE. There is always at least one idle cycle between transactions.
- Latency: a req sampled at edge t gives strobes from t through t+WAIT_CYCLES, and ready in cycle t+WAIT_CYCLES+1.
- Write transactions return rdata = 0.
- Address decode, using the full 64-bit unsigned compare:
  - RAM: address < RAM_SIZE.
  - VGA: VGA_BASE <= address < VGA_BASE+VGA_SIZE.
  - Keyboard: address == KBD_ADDR.
  - Unmapped: no select is asserted, read returns 0, and the transaction still completes normally.
- Once granted, a transaction always completes. Dropping req mid-transaction does not abort it, and ready still pulses.
- A master must hold req until it sees ready. After ready it may re-request on the next cycle.
- A req with neither read nor write set is granted and completes with no strobe asserted. The select still follows the decode, held for the same window.
- Reset asserted mid-transaction immediately forces IDLE, all outputs to 0 and last_grant to 1. No ready is issued.

Test Plan:
- Single write, WAIT_CYCLES=1: m0 writes 64'hDEAD to address 64'h8010 → sel_vga, write and address_bus=64'h8010 high for 2 cycles, data_out=64'hDEAD, then m0_ready pulses 1 cycle.
- Single read: m1 reads KBD_ADDR with data_in=64'h41 → sel_kbd and read high for 2 cycles, then m1_ready with m1_rdata=64'h41, grant=1.
- Contention: both masters request continuously from reset → grants alternate 0,1,0,1. Each transaction is 4 cycles (2 ACCESS, 1 DONE, 1 IDLE).
- Unmapped read at address 64'h5000 → no select asserted, read high for 2 cycles, ready pulses with rdata=0.
- Reset mid-transaction: assert reset during ACCESS → all outputs 0 immediately and no ready pulse. After release, a simultaneous request is granted to m0.
- Zero waits with req dropped: with WAIT_CYCLES=0, m0 drops req one cycle after the grant → strobe high for 1 cycle and m0_ready still pulses.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared system bus.
// Serialises transactions from master 0 (core load/store) and master 1
// (secondary requester), drives the shared address/data/strobes, decodes
// device selects and returns read data with a one-cycle ready pulse.
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   m*_req/read/write/address/wdata   per-master request
//   m*_ready, m*_rdata           per-master completion pulse and read data
//   address_bus, data_out, read, write   shared bus master side
//   data_in                      read data from the selected slave
//   sel_ram, sel_vga, sel_kbd    one-hot device selects
//   grant                        current/last bus owner (0 = m0, 1 = m1)
module bus_arbiter #(
    parameter logic [63:0] VGA_BASE    = 64'h0000_0000_0000_8000,
    parameter logic [63:0] VGA_SIZE    = 64'h0000_0000_0000_1000,
    parameter logic [63:0] KBD_ADDR    = 64'h0000_0000_0000_9000,
    parameter logic [63:0] RAM_SIZE    = 64'h0000_0000_0000_4000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_read,
    input  logic        m1_read,
    input  logic        m0_write,
    input  logic        m1_write,
    input  logic [63:0] m0_address,
    input  logic [63:0] m1_address,
    input  logic [63:0] m0_wdata,
    input  logic [63:0] m1_wdata,
    output logic        m0_ready,
    output logic        m1_ready,
    output logic [63:0] m0_rdata,
    output logic [63:0] m1_rdata,
    output logic [63:0] address_bus,
    output logic [63:0] data_out,
    output logic        read,
    output logic        write,
    input  logic [63:0] data_in,
    output logic        sel_ram,
    output logic        sel_vga,
    output logic        sel_kbd,
    output logic        grant
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               last_grant;

    // Winner selection: round-robin on contention, otherwise the lone requester.
    logic        win_c;
    logic [63:0] win_addr_c;
    logic [63:0] win_wdata_c;
    logic        win_read_c;
    logic        win_write_c;
    logic        ram_hit_c;
    logic        vga_hit_c;
    logic        kbd_hit_c;
    logic        any_sel_c;

    assign win_c       = (m0_req && m1_req) ? ~last_grant : m1_req;
    assign win_addr_c  = win_c ? m1_address : m0_address;
    assign win_wdata_c = win_c ? m1_wdata   : m0_wdata;
    assign win_read_c  = win_c ? m1_read    : m0_read;
    assign win_write_c = win_c ? m1_write   : m0_write;

    // Address decode; priority keeps the selects one-hot even if windows overlap.
    assign ram_hit_c = (win_addr_c < RAM_SIZE);
    assign vga_hit_c = !ram_hit_c && (win_addr_c >= VGA_BASE) &&
                       (win_addr_c < (VGA_BASE + VGA_SIZE));
    assign kbd_hit_c = !ram_hit_c && !vga_hit_c && (win_addr_c == KBD_ADDR);

    // Read data only comes back for a real read of a mapped device.
    assign any_sel_c = sel_ram | sel_vga | sel_kbd;

    // Transaction sequencer with registered bus and completion outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            address_bus <= '0;
            data_out    <= '0;
            read        <= 1'b0;
            write       <= 1'b0;
            sel_ram     <= 1'b0;
            sel_vga     <= 1'b0;
            sel_kbd     <= 1'b0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant       <= win_c;
                        last_grant  <= win_c;
                        address_bus <= win_addr_c;
                        data_out    <= win_wdata_c;
                        write       <= win_write_c;
                        read        <= win_read_c & ~win_write_c;
                        sel_ram     <= ram_hit_c;
                        sel_vga     <= vga_hit_c;
                        sel_kbd     <= kbd_hit_c;
                        wait_cnt    <= CNT_W'(WAIT_CYCLES);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        if (grant) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= (read && any_sel_c) ? data_in : '0;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= (read && any_sel_c) ? data_in : '0;
                        end
                        address_bus <= '0;
                        data_out    <= '0;
                        read        <= 1'b0;
                        write       <= 1'b0;
                        sel_ram     <= 1'b0;
                        sel_vga     <= 1'b0;
                        sel_kbd     <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
